// File: rtl/rvc_pkg.sv
// rtl/rvc_pkg.sv - RV32 opcode/funct constants and encoders shared by the RVC expander
package rvc_pkg;

   typedef enum logic [1:0] {
      Q0 = 2'b00,
      Q1 = 2'b01,
      Q2 = 2'b10,
      Q3 = 2'b11
   } rvc_quad_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // rd'/rs1'/rs2' address x8..x15
   function automatic logic [4:0] creg(input logic [2:0] r);
      return {2'b01, r};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
   endfunction

endpackage

// File: rtl/rvc_expand.sv
// rtl/rvc_expand.sv - combinational RV32C parcel to RV32I instruction expander
module rvc_expand
   import rvc_pkg::*;
(
   input  logic [15:0] parcel,
   output logic [31:0] inst,
   output logic        illegal
);

   logic [4:0]  rd, rs2, rdp, rs1p;
   logic [11:0] imm6, a4spn_imm, lw_imm, a16sp_imm, lwsp_imm, swsp_imm;
   logic [19:0] lui_imm;
   logic [20:1] j_imm;
   logic [12:1] b_imm;
   logic        nz6_zero;

   assign rd        = parcel[11:7];
   assign rs2       = parcel[6:2];
   assign rdp       = creg(parcel[4:2]);
   assign rs1p      = creg(parcel[9:7]);
   assign nz6_zero  = ({parcel[12], parcel[6:2]} == 6'h00);

   // immediate scrambles undone per format
   assign imm6      = {{6{parcel[12]}}, parcel[12], parcel[6:2]};
   assign a4spn_imm = {2'b00, parcel[10:7], parcel[12:11], parcel[5], parcel[6], 2'b00};
   assign lw_imm    = {5'b00000, parcel[5], parcel[12:10], parcel[6], 2'b00};
   assign a16sp_imm = {{3{parcel[12]}}, parcel[4:3], parcel[5], parcel[2], parcel[6], 4'b0000};
   assign lwsp_imm  = {4'b0000, parcel[3:2], parcel[12], parcel[6:4], 2'b00};
   assign swsp_imm  = {4'b0000, parcel[8:7], parcel[12:9], 2'b00};
   assign lui_imm   = {{14{parcel[12]}}, parcel[12], parcel[6:2]};
   assign j_imm     = {{10{parcel[12]}}, parcel[8], parcel[10:9], parcel[6], parcel[7],
                       parcel[2], parcel[11], parcel[5:3]};
   assign b_imm     = {{5{parcel[12]}}, parcel[6:5], parcel[2], parcel[11:10], parcel[4:3]};

   always_comb begin
      inst    = 32'h0000_0000;
      illegal = 1'b0;
      case (rvc_quad_t'(parcel[1:0]))
         Q0: begin
            case (parcel[15:13])
               3'b000: begin
                  inst    = enc_i(a4spn_imm, 5'd2, F3_ADD, rdp, OP_IMM);
                  illegal = (parcel[12:5] == 8'h00);
               end
               3'b010:  inst = enc_i(lw_imm, rs1p, F3_LW, rdp, LOAD);
               3'b110:  inst = enc_s(lw_imm, rdp, rs1p, F3_SW);
               default: illegal = 1'b1;
            endcase
         end
         Q1: begin
            case (parcel[15:13])
               3'b000: inst = enc_i(imm6, rd, F3_ADD, rd, OP_IMM);
               3'b001: inst = enc_j(j_imm, 5'd1);
               3'b010: inst = enc_i(imm6, 5'd0, F3_ADD, rd, OP_IMM);
               3'b011: begin
                  if (rd == 5'd2) begin
                     inst    = enc_i(a16sp_imm, 5'd2, F3_ADD, 5'd2, OP_IMM);
                     illegal = nz6_zero;
                  end else begin
                     inst    = {lui_imm, rd, LUI};
                     illegal = nz6_zero || (rd == 5'd0);
                  end
               end
               3'b100: begin
                  case (parcel[11:10])
                     2'b00: begin
                        inst    = enc_i({F7_BASE, parcel[6:2]}, rs1p, F3_SR, rs1p, OP_IMM);
                        illegal = parcel[12];
                     end
                     2'b01: begin
                        inst    = enc_i({F7_ALT, parcel[6:2]}, rs1p, F3_SR, rs1p, OP_IMM);
                        illegal = parcel[12];
                     end
                     2'b10: inst = enc_i(imm6, rs1p, F3_AND, rs1p, OP_IMM);
                     default: begin
                        // parcel[12]=1 selects RV64-only SUBW/ADDW
                        illegal = parcel[12];
                        case (parcel[6:5])
                           2'b00:   inst = enc_r(F7_ALT, rdp, rs1p, F3_ADD, rs1p, OP);
                           2'b01:   inst = enc_r(F7_BASE, rdp, rs1p, F3_XOR, rs1p, OP);
                           2'b10:   inst = enc_r(F7_BASE, rdp, rs1p, F3_OR, rs1p, OP);
                           default: inst = enc_r(F7_BASE, rdp, rs1p, F3_AND, rs1p, OP);
                        endcase
                     end
                  endcase
               end
               3'b101:  inst = enc_j(j_imm, 5'd0);
               3'b110:  inst = enc_b(b_imm, 5'd0, rs1p, F3_BEQ);
               default: inst = enc_b(b_imm, 5'd0, rs1p, F3_BNE);
            endcase
         end
         Q2: begin
            case (parcel[15:13])
               3'b000: begin
                  inst    = enc_i({F7_BASE, rs2}, rd, F3_SLL, rd, OP_IMM);
                  illegal = parcel[12];
               end
               3'b010: inst = enc_i(lwsp_imm, 5'd2, F3_LW, rd, LOAD);
               3'b100: begin
                  if (!parcel[12]) begin
                     if (rs2 == 5'd0) begin
                        inst    = enc_i(12'h000, rd, F3_JALR, 5'd0, JALR);
                        illegal = (rd == 5'd0);
                     end else begin
                        inst = enc_r(F7_BASE, rs2, 5'd0, F3_ADD, rd, OP);
                     end
                  end else if (rs2 == 5'd0) begin
                     if (rd == 5'd0)
                        inst = enc_i(12'h001, 5'd0, 3'b000, 5'd0, SYSTEM);
                     else
                        inst = enc_i(12'h000, rd, F3_JALR, 5'd1, JALR);
                  end else begin
                     inst = enc_r(F7_BASE, rs2, rd, F3_ADD, rd, OP);
                  end
               end
               3'b110:  inst = enc_s(swsp_imm, rs2, 5'd2, F3_SW);
               default: illegal = 1'b1;
            endcase
         end
         Q3: illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
      if (illegal)
         inst = {16'h0000, parcel};
   end

endmodule

// File: rtl/rvc_fetch_align.sv
// rtl/rvc_fetch_align.sv - halfword parcel buffer, instruction extraction and output register
module rvc_fetch_align
   import rvc_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter bit ENABLE_C = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        flush_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_data_i,
   input  logic [31:0] fetch_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_is_com_o,
   output logic        inst_illegal_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   buf_q [DEPTH];
   logic [AW-1:0] head_q, head_p1, tail, tail_p1;
   logic [CW-1:0] count_q, n_push, n_pop;
   logic [31:0]   head_pc_q, pop_bytes;
   logic          resync_q;

   logic [15:0]   par0, par1;
   logic          head_com, can_issue, out_load, push, skip_lo;
   logic [31:0]   exp_inst, nxt_inst;
   logic          exp_ill, nxt_ill, nxt_com;

   assign tail    = head_q + count_q[AW-1:0];
   assign tail_p1 = tail + AW'(1);
   assign head_p1 = head_q + AW'(1);
   assign par0    = buf_q[head_q];
   assign par1    = buf_q[head_p1];

   // Registered-only ready so decode backpressure never reaches fetch combinationally
   assign fetch_ready_o = rst_n_i & (count_q <= CW'(DEPTH - 2));
   assign push          = fetch_valid_i & fetch_ready_o;
   assign skip_lo       = resync_q & fetch_pc_i[1];
   assign n_push        = push ? (skip_lo ? CW'(1) : CW'(2)) : CW'(0);

   assign head_com  = (par0[1:0] != 2'b11);
   assign can_issue = head_com ? (count_q != CW'(0)) : (count_q >= CW'(2));
   assign out_load  = (!inst_valid_o | inst_ready_i) & can_issue;
   assign n_pop     = out_load ? (head_com ? CW'(1) : CW'(2)) : CW'(0);
   assign pop_bytes = head_com ? 32'd2 : 32'd4;

   rvc_expand u_expand (
      .parcel  (par0),
      .inst    (exp_inst),
      .illegal (exp_ill)
   );

   always_comb begin
      nxt_inst = {par1, par0};
      nxt_com  = 1'b0;
      nxt_ill  = 1'b0;
      if (head_com) begin
         nxt_com = 1'b1;
         if (ENABLE_C) begin
            nxt_inst = exp_inst;
            nxt_ill  = exp_ill;
         end else begin
            nxt_inst = {16'h0000, par0};
            nxt_ill  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         if (skip_lo) begin
            buf_q[tail] <= fetch_data_i[31:16];
         end else begin
            buf_q[tail]    <= fetch_data_i[15:0];
            buf_q[tail_p1] <= fetch_data_i[31:16];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         head_q         <= '0;
         count_q        <= '0;
         head_pc_q      <= '0;
         resync_q       <= 1'b1;
         inst_valid_o   <= 1'b0;
         inst_o         <= '0;
         inst_pc_o      <= '0;
         inst_is_com_o  <= 1'b0;
         inst_illegal_o <= 1'b0;
      end else if (flush_i) begin
         head_q       <= '0;
         count_q      <= '0;
         resync_q     <= 1'b1;
         inst_valid_o <= 1'b0;
      end else begin
         head_q  <= head_q + n_pop[AW-1:0];
         count_q <= count_q + n_push - n_pop;
         // Buffer is empty while resyncing, so no pop competes with the PC load
         if (push && resync_q) begin
            head_pc_q <= fetch_pc_i & 32'hFFFF_FFFE;
            resync_q  <= 1'b0;
         end else if (out_load) begin
            head_pc_q <= head_pc_q + pop_bytes;
         end
         if (out_load) begin
            inst_valid_o   <= 1'b1;
            inst_o         <= nxt_inst;
            inst_pc_o      <= head_pc_q;
            inst_is_com_o  <= nxt_com;
            inst_illegal_o <= nxt_ill;
         end else if (inst_ready_i) begin
            inst_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rvc_fetch_align.sv
// tb/tb_rvc_fetch_align.sv - directed scoreboard bench for rvc_fetch_align
module tb_rvc_fetch_align;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        com;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        rst_n, flush;
   logic        fetch_valid, fetch_ready;
   logic [31:0] fetch_data, fetch_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        inst_com, inst_ill;

   logic        nc_valid, nc_ready, nc_ivalid;
   logic [31:0] nc_data, nc_pc, nc_inst, nc_ipc;
   logic        nc_com, nc_ill;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   logic        stall_prev = 1'b0;
   logic [65:0] prev_out = '0;

   logic [15:0] tp [12];
   logic [31:0] te [12];
   logic        ti [12];

   rvc_fetch_align #(.DEPTH(8), .ENABLE_C(1'b1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
      .fetch_data_i(fetch_data), .fetch_pc_i(fetch_pc),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
      .inst_o(inst), .inst_pc_o(inst_pc),
      .inst_is_com_o(inst_com), .inst_illegal_o(inst_ill)
   );

   rvc_fetch_align #(.DEPTH(8), .ENABLE_C(1'b0)) dut_nc (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(1'b0),
      .fetch_valid_i(nc_valid), .fetch_ready_o(nc_ready),
      .fetch_data_i(nc_data), .fetch_pc_i(nc_pc),
      .inst_valid_o(nc_ivalid), .inst_ready_i(1'b1),
      .inst_o(nc_inst), .inst_pc_o(nc_ipc),
      .inst_is_com_o(nc_com), .inst_illegal_o(nc_ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_inst(input logic [31:0] i, input logic [31:0] pc,
                              input logic com, input logic ill);
      exp_t e;
      e.inst = i; e.pc = pc; e.com = com; e.ill = ill;
      sb.push_back(e);
   endtask

   task automatic push_word(input logic [31:0] d, input logic [31:0] pc);
      int n = 0;
      fetch_valid = 1'b1;
      fetch_data  = d;
      fetch_pc    = pc;
      while (!fetch_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      assert (n < 100) else begin
         fails++;
         $error("FAIL push_timeout: observed %0d cycles expected <100", n);
      end
      @(posedge clk); #1;
      fetch_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   // Output monitor: scoreboard pop on handshake, stability while stalled
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && inst_valid)
            check("stall_stable", {6'b0, inst, inst_pc, inst_com, inst_ill}, {6'b0, prev_out});
         stall_prev = inst_valid && !inst_ready;
         prev_out   = {inst, inst_pc, inst_com, inst_ill};
         if (inst_valid && inst_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
               fails++;
               $error("FAIL unexpected_out: observed inst %h pc %h expected none", inst, inst_pc);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("out", {6'b0, inst, inst_pc, inst_com, inst_ill},
                     {6'b0, e.inst, e.pc, e.com, e.ill});
            end
         end
      end
   end

   initial begin
      int accepted;
      tp = '{16'h4080, 16'h852E, 16'h0000, 16'h8082, 16'h4502, 16'hA001,
             16'h9002, 16'h2000, 16'h1082, 16'hC001, 16'hC080, 16'h0001};
      te = '{32'h0004A403, 32'h00B00533, 32'h00000000, 32'h00008067, 32'h00012503, 32'h0000006F,
             32'h00100073, 32'h00002000, 32'h00001082, 32'h00040063, 32'h0084A023, 32'h00000013};
      ti = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; flush = 1'b0; inst_ready = 1'b1;
      fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0;
      nc_valid = 1'b0; nc_data = '0; nc_pc = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {71'b0, fetch_ready}, 72'd0);
      check("rst_outs", {6'b0, inst, inst_pc, inst_valid, inst_com}, 72'd0);
      check("rst_ill", {71'b0, inst_ill}, 72'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", {71'b0, fetch_ready}, 72'd1);
      @(posedge clk); #1;

      // two compressed in one word, with latency check
      expect_inst(32'h00150513, 32'h100, 1'b1, 1'b0);
      expect_inst(32'h00000013, 32'h102, 1'b1, 1'b0);
      push_word(32'h0001_0505, 32'h100);
      check("t1_lat_n", {71'b0, inst_valid}, 72'd0);
      @(posedge clk); #1;
      check("t1_lat_n1", {71'b0, inst_valid}, 72'd1);
      wait_drain(50);

      // straddling 32-bit instruction
      do_flush();
      expect_inst(32'h00150513, 32'h100, 1'b1, 1'b0);
      push_word(32'h0093_0505, 32'h100);
      wait_drain(50);
      expect_inst(32'h00100093, 32'h102, 1'b0, 1'b0);
      expect_inst(32'h00000013, 32'h106, 1'b1, 1'b0);
      push_word(32'h0001_0010, 32'h104);
      check("strad_lat_n", {71'b0, inst_valid}, 72'd0);
      @(posedge clk); #1;
      check("strad_lat_n1", {71'b0, inst_valid}, 72'd1);
      wait_drain(50);

      // expansion table
      do_flush();
      for (int k = 0; k < 12; k++)
         expect_inst(te[k], 32'h500 + 32'(2 * k), 1'b1, ti[k]);
      for (int k = 0; k < 6; k++)
         push_word({tp[2*k+1], tp[2*k]}, 32'h500);
      wait_drain(100);

      // resync to an odd halfword
      do_flush();
      expect_inst(32'h00150513, 32'h202, 1'b1, 1'b0);
      push_word(32'h0505_0001, 32'h202);
      wait_drain(50);
      @(posedge clk); #1;
      check("resync_only_one", {71'b0, inst_valid}, 72'd0);

      // backpressure: decode stalled for 10 cycles while fetch streams
      do_flush();
      inst_ready = 1'b0;
      accepted = 0;
      for (int c = 0; c < 10; c++) begin
         fetch_valid = 1'b1;
         fetch_data  = 32'h0001_0505;
         fetch_pc    = 32'h600;
         if (fetch_ready) begin
            expect_inst(32'h00150513, 32'h600 + 32'(4 * accepted), 1'b1, 1'b0);
            expect_inst(32'h00000013, 32'h602 + 32'(4 * accepted), 1'b1, 1'b0);
            accepted++;
         end
         @(posedge clk); #1;
      end
      fetch_valid = 1'b0;
      check("stall_ready_low", {71'b0, fetch_ready}, 72'd0);
      check("stall_accepted", 72'(accepted), 72'd4);
      check("stall_valid", {71'b0, inst_valid}, 72'd1);
      inst_ready = 1'b1;
      wait_drain(100);

      // flush while the low half of a 32-bit instruction is buffered
      do_flush();
      expect_inst(32'h00150513, 32'h100, 1'b1, 1'b0);
      push_word(32'h0093_0505, 32'h100);
      wait_drain(50);
      flush = 1'b1;
      fetch_valid = 1'b1;
      fetch_data  = 32'h0010_0001;
      fetch_pc    = 32'h0;
      @(posedge clk); #1;
      flush = 1'b0;
      fetch_valid = 1'b0;
      check("flush_valid", {71'b0, inst_valid}, 72'd0);
      check("flush_ready", {71'b0, fetch_ready}, 72'd1);
      expect_inst(32'h00150513, 32'h300, 1'b1, 1'b0);
      expect_inst(32'h00000013, 32'h302, 1'b1, 1'b0);
      push_word(32'h0001_0505, 32'h300);
      wait_drain(50);

      // reset with an instruction held in the output register
      inst_ready = 1'b0;
      push_word(32'h0001_0505, 32'h800);
      @(posedge clk); #1;
      check("pre_rst_valid", {71'b0, inst_valid}, 72'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", {71'b0, inst_valid}, 72'd0);
      check("mid_rst_outs", {6'b0, inst, inst_pc, inst_com, inst_ill}, 72'd0);
      check("mid_rst_ready", {71'b0, fetch_ready}, 72'd0);
      rst_n = 1'b1;
      inst_ready = 1'b1;
      @(posedge clk); #1;
      expect_inst(32'h00150513, 32'h700, 1'b1, 1'b0);
      expect_inst(32'h00000013, 32'h702, 1'b1, 1'b0);
      push_word(32'h0001_0505, 32'h700);
      wait_drain(50);

      // ENABLE_C=0: every compressed parcel illegal, one parcel each
      check("nc_ready", {71'b0, nc_ready}, 72'd1);
      nc_valid = 1'b1;
      nc_data  = 32'h0001_0505;
      nc_pc    = 32'h100;
      @(posedge clk); #1;
      nc_valid = 1'b0;
      @(posedge clk); #1;
      check("nc_first", {5'b0, nc_ivalid, nc_inst, nc_ipc, nc_com, nc_ill},
            {5'b0, 1'b1, 32'h0000_0505, 32'h100, 1'b1, 1'b1});
      @(posedge clk); #1;
      check("nc_second", {5'b0, nc_ivalid, nc_inst, nc_ipc, nc_com, nc_ill},
            {5'b0, 1'b1, 32'h0000_0001, 32'h102, 1'b1, 1'b1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rvc_fetch_align.md
# rvc_fetch_align

Fetch-side instruction aligner and RVC expander for the rv32imac core. It buffers 32-bit fetch words as halfword parcels and extracts 16-bit and 32-bit instructions, including 32-bit instructions that straddle a word boundary. Compressed instructions are expanded to their RV32I equivalents. Output is one registered instruction per cycle with a PC, over a valid/ready handshake to decode. Decode therefore only ever sees 32-bit encodings, plus an is-compressed flag for PC+2 / PC+4 link and next-PC selection.

## Interface
- `DEPTH`, 8: halfword buffer slots; power of two, ≥4.
- `ENABLE_C`, 1: 1 = expand RVC; 0 = every 16-bit parcel is flagged illegal.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset. One clock; reset is synchronous and active-low.
- `flush_i` in 1: discard all buffered and output state (redirect).
- `fetch_valid_i` in 1: fetch word valid.
- `fetch_ready_o` out 1: buffer can accept a word.
- `fetch_data_i` in 32: little-endian fetch word.
- `fetch_pc_i` in 32: address of the word; bit 1 is meaningful only on resync.
- `inst_valid_o` out 1: instruction valid.
- `inst_ready_i` in 1: decode accepts.
- `inst_o` out 32: expanded 32-bit encoding.
- `inst_pc_o` out 32: address of the instruction's first halfword.
- `inst_is_com_o` out 1: source was a 16-bit parcel.
- `inst_illegal_o` out 1: reserved, unsupported or disabled encoding.

## Operation
- **Buffer:** circular halfword FIFO with `head`, `count` (0..DEPTH) and `head_pc`.
  - Push on `fetch_valid_i & fetch_ready_o`: 2 parcels, low halfword first.
  - If a `resync` bit is set and `fetch_pc_i[1]`=1, push only the high halfword. The first accepted word while `resync`=1 loads `head_pc` from `fetch_pc_i` (with bit 1 honoured), then clears `resync`.
  - `fetch_pc_i` is ignored otherwise; words are assumed sequential.
- **Extract:** the head parcel is compressed when bits[1:0]≠2'b11.
  - Ready to issue when compressed and `count`≥1, or 32-bit and `count`≥2.
  - On issue: pop 1 or 2 parcels, `head_pc` += 2 or 4, mod 2^32.
- **Output register:** loads when `!inst_valid_o | inst_ready_i` and the head is ready to issue.
  - Otherwise holds; `inst_valid_o` clears on accept with nothing ready.
  - Contents are stable while `inst_valid_o & !inst_ready_i`.
- **Expansion (full RV32C integer set):**
  - ADDI4SPN, LW, SW, NOP/ADDI, JAL, LI, ADDI16SP, LUI
  - SRLI, SRAI, ANDI, SUB, XOR, OR, AND, J, BEQZ, BNEZ
  - SLLI, LWSP, JR, MV, EBREAK, JALR, ADD, SWSP
  - Register fields rd'/rs1'/rs2' map to x8–x15.
  - C.ADD / C.MV map to `add`; C.JR / C.JALR map to `jalr` with imm 0 and rd x0 / x1; C.J / C.JAL map to `jal` with rd x0 / x1.
- **Illegal** (`inst_illegal_o`=1, `inst_o`={16'h0, parcel}, one parcel consumed):
  - all-zero parcel; ADDI4SPN with imm=0; ADDI16SP or LUI with imm=0; LUI with rd=x0; JR with rs1=0;
  - shamt[5]=1; any FP parcel (FLD/FSD/FLW/FSW and their SP forms);
  - any 16-bit parcel when `ENABLE_C`=0.
  - HINT encodings (rd=x0 forms of LI, MV, ADD, SLLI, ADDI with imm 0) expand normally.
- **32-bit instructions:** pass through unchanged with `inst_is_com_o`=0.

## Timing
- `fetch_ready_o` = (`count` ≤ DEPTH−2) from registered state only, with no path from `inst_ready_i`. It is forced to 0 while `rst_n_i`=0.
- Latency: a word accepted at edge N gives `inst_valid_o` at N+1 when the output register is free. A straddling instruction issues the cycle after its second word is accepted.
- Throughput: 1 instruction/cycle. A word holding two compressed instructions drains in 2 cycles.
- Simultaneous push and pop are allowed; `count` += pushed − popped.
- `flush_i` has priority over everything. A fetch handshake in the flush cycle is dropped. Next cycle: `count`=0, `inst_valid_o`=0, `resync`=1.
- Reset, including reset mid-instruction: `count`=0, `head`=0, `head_pc`=0, `resync`=1. All outputs are 0.

## Structure
- Package `rvc_pkg`:
  - opcode constants: OP_IMM, OP, LOAD, STORE, LUI, JAL, JALR, BRANCH, SYSTEM;
  - funct3/funct7 constants;
  - a function mapping a 3-bit compressed register field to its 5-bit register.
- Sub-module `rvc_expand`: purely combinational; 16-bit parcel in, `{inst[31:0], illegal}` out. Reused by a future trace decoder.
- Top module: FIFO, pointers, resync bit, output register.

## Test plan
- Word 32'h0001_0505 @0x100 → `inst_o` 32'h00150513 @0x100 com=1, then 32'h00000013 @0x102 com=1.
- Word 32'h0093_0505 @0x100, then 32'h0001_0010 @0x104 → 32'h00150513 @0x100; 32'h00100093 @0x102 com=0; 32'h00000013 @0x106.
- Expansion checks:
  - 16'h4080 → 32'h0004A403 (lw x8,0(x9));
  - 16'h852E → 32'h00B00533;
  - 16'h0000 → illegal=1, `inst_o`=0.
- Resync at `fetch_pc_i`=0x202 with word 32'h0505_0001 → only 16'h0505 issues, at PC 0x202.
- Hold `inst_ready_i`=0 for 10 cycles while streaming → `fetch_ready_o` falls once `count` > DEPTH−2. Output stays stable; no parcel is lost or duplicated after release.
- Assert `flush_i` mid-straddle, and separately pull `rst_n_i` low mid-stream → next cycle `inst_valid_o`=0. The first post-flush word issues from its own `fetch_pc_i`.
- With `ENABLE_C`=0, 16'h0505 → illegal=1 and 1 parcel consumed.
